// File: rtl/if_stage.sv
// Purpose: instruction fetch stage; generates nextpc, reads the instruction SRAM, hands {inst, pc} to ID.
// Latency: SRAM data returns one cycle after the request; an instruction is offered to ID the cycle after its PC is issued.
// Backpressure: ds_allowin=0 holds fs_pc, suppresses SRAM reads and buffers the returned word; br_taken always redirects.
//
// Ports:
//   clk, reset                        single clock, synchronous active-high reset
//   ds_allowin                        ID can accept an instruction this cycle
//   br_taken, br_target               single-cycle redirect request from EX
//   fs_to_ds_valid, fs_to_ds_bus      {inst[63:32], pc[31:0]} offered to ID
//   inst_sram_en/we/addr/wdata/rdata  read-only instruction SRAM port (we/wdata tied to zero)
module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    // Chosen so that the first sequential fetch after reset lands on 0x1c000000.
    localparam logic [31:0] RESET_PC = 32'h1bff_fffc;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_bus_t;

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        issued_q, issued_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_allowin;
    logic        ds_handshake;
    logic        buf_capture;
    logic [31:0] fs_inst;
    fs_bus_t     fs_bus;

    always_comb begin
        seq_pc         = fs_pc_q + 32'd4;
        nextpc         = br_taken ? br_target : seq_pc;
        fs_allowin     = !fs_valid_q || ds_allowin || br_taken;
        inst_sram_en   = !reset && fs_allowin;
        fs_to_ds_valid = fs_valid_q && !br_taken;
        ds_handshake   = fs_to_ds_valid && ds_allowin;

        // The SRAM only presents the word for one cycle; if ID stalls on that
        // cycle it must be parked here, since no re-read is issued while stalled.
        buf_capture    = fs_valid_q && issued_q && !ds_allowin && !br_taken;

        fs_inst        = buf_valid_q ? inst_buf_q : inst_sram_rdata;
        fs_bus.inst    = fs_inst;
        fs_bus.pc      = fs_pc_q;

        fs_valid_d  = fs_valid_q;
        fs_pc_d     = fs_pc_q;
        if (fs_allowin) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
        end

        issued_d    = inst_sram_en;

        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        if (ds_handshake || br_taken) begin
            buf_valid_d = 1'b0;
        end else if (buf_capture) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q  <= 1'b0;
            fs_pc_q     <= RESET_PC;
            issued_q    <= 1'b0;
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'h0;
        end else begin
            fs_valid_q  <= fs_valid_d;
            fs_pc_q     <= fs_pc_d;
            issued_q    <= issued_d;
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    assign fs_to_ds_bus    = fs_bus;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL expose the following ports, one per line (name, direction, width, meaning), clock and reset first.
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ds_allowin  input  1  ID stage can accept an instruction this cycle.
- br_taken  input  1  redirect request from EX, single-cycle pulse.
- br_target  input  32  redirect PC; valid when br_taken=1.
- fs_to_ds_valid  output  1  IF holds a valid instruction for ID.
- fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.
- inst_sram_en  output  1  instruction SRAM read enable.
- inst_sram_we  output  4  tied 4'b0.
- inst_sram_addr  output  32  fetch address (nextpc).
- inst_sram_wdata  output  32  tied 32'b0.
- inst_sram_rdata  input  32  read data; valid exactly one cycle after an enabled read.
REQ-002 Reset SHALL be synchronous and active-high on port reset, clocked by clk; no other clock or reset exists.

Function
REQ-003 seq_pc SHALL be fs_pc + 4, computed modulo 2^32 (0xfffffffc + 4 wraps to 0x00000000).
REQ-004 nextpc SHALL be br_target when br_taken=1, otherwise seq_pc.
REQ-005 fs_allowin SHALL be: !fs_valid OR ds_allowin OR br_taken.
REQ-006 inst_sram_en SHALL be !reset AND fs_allowin; inst_sram_addr SHALL equal nextpc at all times.
REQ-007 When fs_allowin=1 and reset=0, on the clock edge: fs_valid<=1, fs_pc<=nextpc.
REQ-008 When fs_allowin=0: fs_pc and fs_valid hold; no SRAM read is issued.
REQ-009 issued_q SHALL register inst_sram_en each cycle; inst_sram_rdata is consumed only when issued_q=1.
REQ-010 Inst buffer: when fs_valid=1, issued_q=1, ds_allowin=0, br_taken=0, the block SHALL capture inst_sram_rdata into inst_buf and set buf_valid=1.
REQ-011 fs_inst SHALL be inst_buf when buf_valid=1, otherwise inst_sram_rdata.
REQ-012 buf_valid SHALL clear on any cycle where the IF->ID handshake completes (fs_to_ds_valid AND ds_allowin) or br_taken=1.
REQ-013 fs_to_ds_valid SHALL be fs_valid AND !br_taken; the instruction in IF during a br_taken cycle is discarded and never delivered.
REQ-014 The handshake SHALL transfer exactly one instruction per cycle where fs_to_ds_valid=1 and ds_allowin=1; fs_to_ds_bus SHALL stay stable while fs_to_ds_valid=1 and ds_allowin=0.
REQ-015 br_taken concurrent with ds_allowin=0 SHALL still redirect: fs_pc<=br_target, buffer cleared, and the target is read in that cycle.
REQ-016 br_taken concurrent with a stall release SHALL behave identically to REQ-015; the redirect has priority over the sequential path.
REQ-017 Throughput: with ds_allowin held at 1 and no branches, one new PC SHALL be delivered per cycle, with PCs increasing by 4.

Reset
REQ-018 During reset: fs_valid=0, buf_valid=0, issued_q=0, inst_buf=0, fs_pc=0x1bfffffc, inst_sram_en=0, fs_to_ds_valid=0.
REQ-019 The first cycle after reset deassertion SHALL issue a read at nextpc=0x1c000000; fs_to_ds_valid SHALL rise in the following cycle with fs_pc=0x1c000000.
REQ-020 Reset asserted mid-stall or mid-redirect SHALL discard all state within one edge; buffered instructions are lost.

Verification
REQ-021 Reset for 3 cycles, then release, ds_allowin=1 -> requests to 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; outputs follow one cycle later, with inst matching SRAM contents.
REQ-022 Hold ds_allowin=0 for 5 cycles while fs_pc=0x1c000008 -> inst_sram_en=0, and the bus holds {mem[0x1c000008], 0x1c000008} even if rdata is driven with garbage; on release, the next delivered PC is 0x1c00000c.
REQ-023 Pulse br_taken with br_target=0x1c000100 while fs_pc=0x1c000010 -> fs_to_ds_valid=0 that cycle, 0x1c000010 is never delivered, and the next delivered PC is 0x1c000100.
REQ-024 Pulse br_taken with br_target=0x1c000200 during a 3-cycle stall -> the buffer is cleared, and after the stall ends the delivered PC is 0x1c000200 with inst=mem[0x1c000200].
REQ-025 Assert reset while a stalled instruction is buffered -> fs_to_ds_valid=0 next cycle; after release, fetch restarts at 0x1c000000.
REQ-026 Force fs_pc=0xfffffffc with ds_allowin=1 -> the next request address is 0x00000000.
